arm_multicycle_ctrl: RTL

Multicycle control unit for the ARM-subset datapath (ADD/SUB/AND/ORR, LDR/STR, B).
- Sequences one instruction over 3–5 cycles through a Moore main FSM.
- Decodes the latched instruction register.
- Holds the NZCV flags register and evaluates the condition field.
- Gates every architectural write enable, so a failed condition causes no state change.

---
 rtl/arm_multicycle_ctrl_pkg.sv | 77 +++++++
 rtl/arm_multicycle_ctrl_cond_check.sv | 72 +++++++
 rtl/arm_multicycle_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/arm_multicycle_ctrl_pkg.sv
// Shared types and encodings for the ARM-subset multicycle controller.
// The optional memory wait-state feature is enabled by defining CTRL_MEM_WAIT_EN.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } ctrl_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_ROT8 = 2'b00;
    localparam logic [1:0] IMM_12   = 2'b01;
    localparam logic [1:0] IMM_24   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic       reg_write;
    } ctrl_out_t;

endpackage

// File: rtl/arm_multicycle_ctrl_cond_check.sv
// Condition-field evaluation against the NZCV flags register, plus that register.
// Logical ops (AND/ORR) update only N and Z; C and V are held.
module cond_check
    import arm_ctrl_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cond_i,
    input  logic [FLAG_W-1:0] alu_flags_i,
    input  logic              flag_write_i,
    input  logic              logic_op_i,
    output logic [FLAG_W-1:0] flags_o,
    output logic              cond_ex_o
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic n, z, c, v;

    assign n = flags_q[FLAG_N];
    assign z = flags_q[FLAG_Z];
    assign c = flags_q[FLAG_C];
    assign v = flags_q[FLAG_V];

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

    // A failed condition must leave the flags untouched as well.
    always_comb begin
        flags_d = flags_q;
        if (flag_write_i && cond_ex_o) begin
            flags_d[FLAG_N] = alu_flags_i[FLAG_N];
            flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
            if (!logic_op_i) begin
                flags_d[FLAG_C] = alu_flags_i[FLAG_C];
                flags_d[FLAG_V] = alu_flags_i[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle Moore controller for ADD/SUB/AND/ORR, LDR/STR and B with conditional execution.
// Define CTRL_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR until MemReady is high.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int          FLAG_W      = 4,
    parameter ctrl_state_t RESET_STATE = FETCH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instr,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic              MemReady,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ALUControl,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic              RegWrite,
    output logic [FLAG_W-1:0] Flags,
    output ctrl_state_t       state_o
);

    ctrl_state_t state_q, state_d;
    ctrl_out_t   out_q, out_d;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit, s_bit, l_bit;
    logic       rd_is_pc, dp_nop, logic_op;
    logic [1:0] alu_ctrl;
    logic       cond_ex, flag_write, mem_ready;
    logic       unused_bits;

    assign op       = Instr[27:26];
    assign i_bit    = Instr[25];
    assign cmd      = Instr[24:21];
    assign s_bit    = Instr[20];
    assign l_bit    = Instr[20];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign logic_op = (cmd == CMD_AND) || (cmd == CMD_ORR);
    assign dp_nop   = !((cmd == CMD_ADD) || (cmd == CMD_SUB) || logic_op);

    assign unused_bits = ^{Instr[19:16], Instr[11:0], MemReady};

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (cmd)
            CMD_SUB: alu_ctrl = ALU_SUB;
            CMD_AND: alu_ctrl = ALU_AND;
            CMD_ORR: alu_ctrl = ALU_ORR;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = IMM_ROT8;
        case (op)
            OP_MEM:  ImmSrc = IMM_12;
            OP_BR:   ImmSrc = IMM_24;
            default: ImmSrc = IMM_ROT8;
        endcase
    end

    assign RegSrc = {op == OP_MEM, op == OP_BR};

    // Flags load on the edge that ends an execute state; NOP commands leave them alone.
    assign flag_write = ((state_q == EXECR) || (state_q == EXECI)) && s_bit && !dp_nop;

    cond_check #(
        .FLAG_W (FLAG_W)
    ) u_cond_check (
        .clk          (clk),
        .reset        (reset),
        .cond_i       (Instr[31:28]),
        .alu_flags_i  (ALUFlags),
        .flag_write_i (flag_write),
        .logic_op_i   (logic_op),
        .flags_o      (Flags),
        .cond_ex_o    (cond_ex)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_DP:   state_d = i_bit ? EXECI : EXECR;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            MEMADR:  state_d = l_bit ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_ready) state_d = FETCH;
            BRANCH:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Outputs are registered from the next state, so write enables for ALUWB
    // are fixed with the flags as they stood before the execute-edge update.
    function automatic ctrl_out_t state_outputs(ctrl_state_t st, logic cex, logic wb_pc,
                                                logic wb_ok, logic [1:0] alu);
        ctrl_out_t o;
        o = '0;
        case (st)
            FETCH: begin
                o.ir_write    = 1'b1;
                o.pc_write    = 1'b1;
                o.alu_src_a   = 1'b1;
                o.alu_src_b   = SRCB_FOUR;
                o.alu_control = ALU_ADD;
                o.result_src  = RES_ALU;
            end
            DECODE: begin
                o.alu_src_a  = 1'b1;
                o.alu_src_b  = SRCB_FOUR;
                o.result_src = RES_ALU;
            end
            EXECR:  o.alu_control = alu;
            EXECI: begin
                o.alu_src_b   = SRCB_IMM;
                o.alu_control = alu;
            end
            ALUWB: begin
                o.result_src = RES_ALUOUT;
                o.reg_write  = cex & wb_ok & ~wb_pc;
                o.pc_write   = cex & wb_ok & wb_pc;
            end
            MEMADR: o.alu_src_b = SRCB_IMM;
            MEMRD:  o.adr_src = 1'b1;
            MEMWR: begin
                o.adr_src   = 1'b1;
                o.mem_write = cex;
            end
            MEMWB: begin
                o.result_src = RES_DATA;
                o.reg_write  = cex;
            end
            BRANCH: begin
                o.alu_src_b  = SRCB_IMM;
                o.result_src = RES_ALU;
                o.pc_write   = cex;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    assign out_d = state_outputs(state_d, cond_ex, rd_is_pc, ~dp_nop, alu_ctrl);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            out_q   <= state_outputs(RESET_STATE, 1'b0, 1'b0, 1'b0, ALU_ADD);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // While FETCH waits on memory, the PC/IR loads fire only in the ready cycle.
    assign IRWrite    = out_q.ir_write & mem_ready;
    assign PCWrite    = out_q.pc_write & (mem_ready | (state_q != FETCH));
    assign AdrSrc     = out_q.adr_src;
    assign MemWrite   = out_q.mem_write;
    assign ResultSrc  = out_q.result_src;
    assign ALUSrcA    = out_q.alu_src_a;
    assign ALUSrcB    = out_q.alu_src_b;
    assign ALUControl = out_q.alu_control;
    assign RegWrite   = out_q.reg_write;
    assign state_o    = state_q;

endmodule
